gpio_access_arbiter: RTL and testbench

GPIO_ACCESS_ARBITER -- requirements
Module: gpio_access_arbiter

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_access_arbiter_if.sv | 45 ++++
 rtl/rr_arb2.sv | 20 ++
 rtl/gpio_access_arbiter.sv | 90 +++++++++
 tb/tb_gpio_access_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared types for the GPIO access arbiter: FSM state encodings and requester ids.
// Pure declarations, no logic; imported by interface, arbiter and top.
// No handshake of its own.
package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Requester ids; the round-robin pointer uses the same encoding to name the favoured side.
  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  localparam int ADDR_W = 2;

endpackage

// File: rtl/gpio_access_arbiter_if.sv
// Bundle of both requester ports, the decoder port and the read-data return.
// Wires only, zero latency.
// Requesters hold req/we/addr/wdata until their done pulse.
interface gpio_access_arbiter_if
  import gpio_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_done;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_done;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] dec_a;
  logic              dec_we;
  logic [DATA_W-1:0] dec_wd;
  logic [DATA_W-1:0] dec_rd;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  dec_rd,
    output m0_done, m1_done, rdata, dec_a, dec_we, dec_wd
  );

  // Requester / decoder side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output dec_rd,
    input  m0_done, m1_done, rdata, dec_a, dec_we, dec_wd
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector producing a one-hot grant.
// Purely combinational, zero latency.
// The pointer only breaks ties; a lone request is always granted.
module rr_arb2
  import gpio_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Pass single requests straight through; on contention grant the side the pointer favours.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (ptr == ID_M1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Shares one GPIO register port between a processor (m0) and an accelerator (m1).
// Latency: req seen in IDLE at edge N -> dec_we cycle N+1 -> done cycle N+2.
// No queueing: requests are only sampled in IDLE; a new grant at most every 3 cycles.
module gpio_access_arbiter
  import gpio_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  gpio_access_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        gnt;
  logic              ptr;
  logic              win_id;
  logic              lat_we;
  logic [ADDR_W-1:0] dec_a_q;
  logic [DATA_W-1:0] dec_wd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              dec_we_c;
  logic              m0_done_c;
  logic              m1_done_c;

  rr_arb2 u_arb (
    .req ({bus.m1_req, bus.m0_req}),
    .ptr (ptr),
    .gnt (gnt)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: one grant walks IDLE -> ISSUE -> RESP -> IDLE unconditionally.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's command on grant, capture read data leaving ISSUE, rotate priority in RESP.
  // dec_a/dec_wd are the latched copies, so they naturally hold outside ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_id   <= ID_M0;
      lat_we   <= 1'b0;
      dec_a_q  <= '0;
      dec_wd_q <= '0;
      rdata_q  <= '0;
      ptr      <= ID_M0;
    end else begin
      if (state == IDLE && |gnt) begin
        win_id   <= gnt[1] ? ID_M1 : ID_M0;
        lat_we   <= gnt[1] ? bus.m1_we    : bus.m0_we;
        dec_a_q  <= gnt[1] ? bus.m1_addr  : bus.m0_addr;
        dec_wd_q <= gnt[1] ? bus.m1_wdata : bus.m0_wdata;
      end
      if (state == ISSUE) begin
        rdata_q <= bus.dec_rd;
      end
      if (state == RESP) begin
        ptr <= (win_id == ID_M0) ? ID_M1 : ID_M0;
      end
    end
  end

  // Strobes decoded from state so reset clears them without waiting for an edge.
  always_comb begin
    dec_we_c  = (state == ISSUE) && lat_we;
    m0_done_c = (state == RESP) && (win_id == ID_M0);
    m1_done_c = (state == RESP) && (win_id == ID_M1);
  end

  assign bus.dec_we  = dec_we_c;
  assign bus.m0_done = m0_done_c;
  assign bus.m1_done = m1_done_c;
  assign bus.dec_a   = dec_a_q;
  assign bus.dec_wd  = dec_wd_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Directed bench for gpio_access_arbiter: single write, single read, contention,
// reset mid-transaction and an ignored short pulse. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_gpio_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  gpio_access_arbiter_if #(.DATA_W(32)) bus ();

  gpio_access_arbiter #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 2'd0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 2'd0; bus.m1_wdata = 32'h0;
    bus.dec_rd = 32'h0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int ids[8];
  int tms[8];
  int n_done;
  int both_hi;
  int m1_seen;
  int m0_seen;
  int done_in_rst;

  initial begin
    idle_inputs();
    cycles(2);

    // Reset state.
    check_eq("rst_dec_we", bus.dec_we, 0);
    check_eq("rst_dec_a", bus.dec_a, 0);
    check_eq("rst_dec_wd", bus.dec_wd, 0);
    check_eq("rst_rdata", bus.rdata, 0);
    check_eq("rst_dones", {bus.m0_done, bus.m1_done}, 0);
    rst = 1'b0;
    cycles(1);

    // m0 write addr 2, data A5.
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 2'd2; bus.m0_wdata = 32'h0000_00A5;
    cycles(1);
    check_eq("wr_dec_we_n1", bus.dec_we, 1);
    check_eq("wr_dec_a_n1", bus.dec_a, 2);
    check_eq("wr_dec_wd_n1", bus.dec_wd, 32'hA5);
    check_eq("wr_done_n1", bus.m0_done, 0);
    cycles(1);
    check_eq("wr_m0_done_n2", bus.m0_done, 1);
    check_eq("wr_m1_done_n2", bus.m1_done, 0);
    check_eq("wr_dec_we_n2", bus.dec_we, 0);
    bus.m0_req = 1'b0; bus.m0_we = 1'b0;
    cycles(1);
    check_eq("wr_done_n3", bus.m0_done, 0);
    check_eq("wr_dec_a_hold", bus.dec_a, 2);
    check_eq("wr_dec_wd_hold", bus.dec_wd, 32'hA5);

    // m1 read addr 3.
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 2'd3; bus.dec_rd = 32'h1234_5678;
    cycles(1);
    check_eq("rd_dec_we_n1", bus.dec_we, 0);
    check_eq("rd_dec_a_n1", bus.dec_a, 3);
    check_eq("rd_done_n1", bus.m1_done, 0);
    cycles(1);
    check_eq("rd_m1_done_n2", bus.m1_done, 1);
    check_eq("rd_m0_done_n2", bus.m0_done, 0);
    check_eq("rd_rdata_n2", bus.rdata, 32'h1234_5678);
    check_eq("rd_dec_we_n2", bus.dec_we, 0);
    bus.m1_req = 1'b0;
    bus.dec_rd = 32'hDEAD_BEEF;
    cycles(1);
    check_eq("rd_rdata_hold", bus.rdata, 32'h1234_5678);
    check_eq("rd_done_n3", bus.m1_done, 0);

    // Both requesters held high from reset: m0, m1, m0, m1, 3 cycles apart.
    rst = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 2'd1; bus.m0_wdata = 32'h11;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 2'd0; bus.m1_wdata = 32'h22;
    cycles(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin ids[i] = -1; tms[i] = -1; end
    n_done = 0; both_hi = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.m0_done && bus.m1_done) both_hi++;
      if ((bus.m0_done || bus.m1_done) && n_done < 8) begin
        ids[n_done] = bus.m1_done ? 1 : 0;
        tms[n_done] = c;
        n_done++;
      end
    end
    check_eq("rr_both_done", both_hi, 0);
    check_eq("rr_count", n_done, 4);
    check_eq("rr_id0", ids[0], 0);
    check_eq("rr_id1", ids[1], 1);
    check_eq("rr_id2", ids[2], 0);
    check_eq("rr_id3", ids[3], 1);
    check_eq("rr_t0", tms[0], 2);
    check_eq("rr_gap1", tms[1] - tms[0], 3);
    check_eq("rr_gap2", tms[2] - tms[1], 3);
    check_eq("rr_gap3", tms[3] - tms[2], 3);
    idle_inputs();
    cycles(4);

    // Serve m0 alone so the pointer favours m1, then abort an m0 write in ISSUE.
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 2'd1;
    cycles(2);
    check_eq("pre_m0_done", bus.m0_done, 1);
    bus.m0_req = 1'b0;
    cycles(1);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 2'd1; bus.m0_wdata = 32'h55;
    cycles(1);
    check_eq("abort_dec_we_issue", bus.dec_we, 1);
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 2'd2;
    rst = 1'b1;
    #1;
    check_eq("abort_dec_we_async", bus.dec_we, 0);
    check_eq("abort_dec_a", bus.dec_a, 0);
    check_eq("abort_dec_wd", bus.dec_wd, 0);
    done_in_rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.m0_done || bus.m1_done) done_in_rst++;
    end
    check_eq("abort_no_done", done_in_rst, 0);
    rst = 1'b0;
    cycles(2);
    check_eq("abort_next_m0", bus.m0_done, 1);
    check_eq("abort_next_not_m1", bus.m1_done, 0);
    idle_inputs();
    cycles(4);

    // m1 pulses for one cycle while m0 is in ISSUE: never granted.
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 2'd0;
    cycles(1);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 2'd3;
    cycles(1);
    bus.m1_req = 1'b0;
    m0_seen = bus.m0_done ? 1 : 0;
    bus.m0_req = 1'b0;
    m1_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.m1_done) m1_seen++;
      if (bus.m0_done) m0_seen++;
      if (bus.dec_we) m1_seen++;
    end
    check_eq("pulse_m0_served", m0_seen, 1);
    check_eq("pulse_m1_ignored", m1_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
